// File: rtl/flit_queue_reader.sv
// flit_queue_reader: first-word-fall-through flit queue between a router input
// channel and the switch allocator.
//
// Ports:
//   clk          - clock, all state updates on the rising edge
//   rst          - synchronous, active-high reset
//   write_en_i   - push request; write_data_i captured when accepted
//   write_data_i - flit to enqueue
//   full_o       - queue holds DEPTH flits (upstream flow control)
//   valid_o      - head flit present on read_data_o
//   read_data_o  - head flit, all-zero when empty
//   yumi_i       - consumer pops the head this cycle
//   count_o      - number of stored flits, 0..DEPTH
//   overflow_o   - sticky: write attempted while full and not popping
//   underflow_o  - sticky: yumi_i asserted while empty
module flit_queue_reader #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_en_i,
    input  logic [WIDTH-1:0] write_data_i,
    output logic             full_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] read_data_o,
    input  logic             yumi_i,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             push, pop;

    // Flags come only from registered state, so the head is stable for the
    // whole cycle regardless of what the consumer does.
    assign valid_o     = (count_q != '0);
    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign read_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

    // A pop frees the head slot in the same cycle, so a full queue can still
    // accept a write alongside it. No bypass when empty.
    assign pop  = yumi_i && valid_o;
    assign push = write_en_i && (!full_o || pop);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;  // power-of-two depth: natural wrap
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if (write_en_i && full_o && !pop) begin
            overflow_d = 1'b1;
        end
        if (yumi_i && !valid_o) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; valid_o masks stale contents.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= write_data_i;
        end
    end

endmodule
